// File: rtl/dither_pkg.sv
// +------------------------------------------------------------------+
// | dither_pkg : shared constants, TX state encoding and CRC-8 helper |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package dither_pkg;

  localparam int         IMAGE_SIZE       = 4096;
  localparam int         IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE);
  localparam int         RGB_SIZE         = 8;
  localparam logic [7:0] CRC8_POLY        = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_PREFETCH = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_DONE     = 3'd5
  } tx_state_t;

  // MSB-first CRC-8, no reflection, one whole byte per call
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_pixel_tx_sync_edge.sv
// +------------------------------------------------------------------+
// | spi_sync_edge : 2-FF synchronizer with registered rise/fall pulses|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  // level taken from prev_q so it lines up with the edge pulses
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_pixel_tx.sv
// +------------------------------------------------------------------+
// | spi_pixel_tx : SPI mode-0 slave that streams the image RAM out   |
// | on MISO. Define SPI_TX_CRC_EN to append a CRC-8 trailer byte.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module spi_pixel_tx #(
  parameter int IMAGE_SIZE       = dither_pkg::IMAGE_SIZE,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             SPI_CLK,
  input  logic                             SPI_CS,
  output logic                             SPI_MISO,
  output logic                             data_valid,
  output logic                             RD_RAM,
  output logic [IMAGE_ADDR_WIDTH-1:0]      RD_RAM_ADDR,
  input  logic [dither_pkg::RGB_SIZE-1:0]  ram_out,
  output logic                             busy,
  output logic                             done
);

  import dither_pkg::*;

`ifdef SPI_TX_CRC_EN
  localparam int TOTAL_BYTES = IMAGE_SIZE + 1;
`else
  localparam int TOTAL_BYTES = IMAGE_SIZE;
`endif
  localparam int                          CNT_W       = $clog2(TOTAL_BYTES + 1);
  localparam logic [CNT_W-1:0]            C_IMG_CNT   = CNT_W'(IMAGE_SIZE);
  localparam logic [CNT_W-1:0]            C_TOT_CNT   = CNT_W'(TOTAL_BYTES);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] C_LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  logic sclk_rise, sclk_fall, sclk_level;
  logic cs_rise, cs_fall, cs_level;
  logic unused_sync;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (SPI_CLK),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (SPI_CS),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign unused_sync = sclk_level ^ cs_fall;

  tx_state_t                   state_q;
  logic [IMAGE_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]            rd_cnt_q, sent_q, sent_d;
  logic [7:0]                  shift_q, shadow_q, hold_q;
  logic [2:0]                  bit_cnt_q;
  logic                        hold_vld_q, valid_q, rd_q, busy_q, done_q;
  logic                        active, byte_end;
`ifdef SPI_TX_CRC_EN
  logic [7:0]                  crc_q, crc_d;
  assign crc_d = crc8_update(crc_q, shadow_q);
`endif

  assign active   = valid_q & ~cs_level;
  assign byte_end = active & sclk_rise & (bit_cnt_q == 3'd7);
  assign sent_d   = sent_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      sent_q     <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      hold_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_TX_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;

      // Bit engine runs in every state so SCLK edges are never dropped
      if (active && sclk_rise) begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_q <= '0;
          sent_q    <= sent_d;
`ifdef SPI_TX_CRC_EN
          crc_q     <= crc_d;
`endif
          if (hold_vld_q) begin
            shift_q    <= hold_q;
            shadow_q   <= hold_q;
            hold_vld_q <= 1'b0;
`ifdef SPI_TX_CRC_EN
          end else if (sent_d == C_IMG_CNT) begin
            shift_q    <= crc_d;
            shadow_q   <= crc_d;
`endif
          end else begin
            valid_q <= 1'b0;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else if (active && sclk_fall && bit_cnt_q != 3'd0) begin
        shift_q <= {shift_q[6:0], 1'b0};
      end else if (valid_q && cs_rise && bit_cnt_q != 3'd0) begin
        // Master gave up mid-byte: rewind so the next select replays it
        shift_q   <= shadow_q;
        bit_cnt_q <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            sent_q     <= '0;
            bit_cnt_q  <= '0;
            hold_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            rd_q       <= 1'b1;
`ifdef SPI_TX_CRC_EN
            crc_q      <= '0;
`endif
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          if (!valid_q) begin
            shift_q  <= ram_out;
            shadow_q <= ram_out;
            valid_q  <= 1'b1;
          end else begin
            hold_q     <= ram_out;
            hold_vld_q <= 1'b1;
          end
          addr_q   <= (addr_q == C_LAST_ADDR) ? '0 : addr_q + IMAGE_ADDR_WIDTH'(1);
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          state_q  <= ST_PREFETCH;
        end
        ST_PREFETCH: begin
          if (!hold_vld_q && rd_cnt_q != C_IMG_CNT) begin
            rd_q    <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (byte_end) begin
            if (sent_d == C_TOT_CNT) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              state_q <= ST_DONE;
            end else if (rd_cnt_q != C_IMG_CNT) begin
              rd_q    <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SPI_MISO    = ~SPI_CS & valid_q & shift_q[7];
  assign data_valid  = valid_q;
  assign RD_RAM      = rd_q;
  assign RD_RAM_ADDR = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire
